// File: rtl/font5x7_pkg.sv
// Shared 5x7 font, colour key and mode encodings for the overlay generators.
package font5x7_pkg;

  localparam logic [5:0] COLOR_TRANSPARENT = 6'b100001;

  // Tracker / scroll field widths: up to 16 chars, pitch up to 255 pixels.
  localparam int CI_W = 4;
  localparam int PX_W = 8;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_TYPE   = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // One 5-bit glyph row, bit4 = leftmost column. Codes outside A-Z are blank.
  function automatic logic [4:0] glyph_row(input logic [7:0] ch, input logic [2:0] row);
    logic [34:0] g;
    g = '0;
    case (ch)
      8'h41: g = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11}; // A
      8'h42: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E}; // B
      8'h43: g = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E}; // C
      8'h44: g = {5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E}; // D
      8'h45: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F}; // E
      8'h46: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10}; // F
      8'h47: g = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F}; // G
      8'h48: g = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11}; // H
      8'h49: g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E}; // I
      8'h4A: g = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C}; // J
      8'h4B: g = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11}; // K
      8'h4C: g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F}; // L
      8'h4D: g = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11}; // M
      8'h4E: g = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11}; // N
      8'h4F: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E}; // O
      8'h50: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10}; // P
      8'h51: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D}; // Q
      8'h52: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11}; // R
      8'h53: g = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E}; // S
      8'h54: g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04}; // T
      8'h55: g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E}; // U
      8'h56: g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04}; // V
      8'h57: g = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A}; // W
      8'h58: g = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11}; // X
      8'h59: g = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04, 5'h04}; // Y
      8'h5A: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F}; // Z
      default: g = '0;
    endcase
    case (row)
      3'd0:    return g[34:30];
      3'd1:    return g[29:25];
      3'd2:    return g[24:20];
      3'd3:    return g[19:15];
      3'd4:    return g[14:10];
      3'd5:    return g[9:5];
      3'd6:    return g[4:0];
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/text_anim_ctrl.sv
// Animation control: frame divider, mode latch and per-mode animation state.
module text_anim_ctrl import font5x7_pkg::*; #(
  parameter int NUM_CHARS       = 12,
  parameter int PITCH           = 12,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic [1:0]      mode,
  output mode_e           mode_q,
  output logic [4:0]      reveal_cnt,
  output logic [CI_W-1:0] scroll_ci,
  output logic [PX_W-1:0] scroll_px,
  output logic            blink_ph,
  output logic            done
);

  localparam logic [7:0]      FD_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [4:0]      REV_MAX = 5'(NUM_CHARS);
  localparam logic [CI_W-1:0] CI_LAST = CI_W'(NUM_CHARS - 1);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(PITCH - 1);

  logic [7:0] frame_div;
  mode_e      mode_in;
  logic       mode_chg;
  logic       step;

  // A mode change restarts the animation and suppresses that frame's step.
  assign mode_in  = mode_e'(mode);
  assign mode_chg = frame_start && (mode_in != mode_q);
  assign step     = frame_start && !mode_chg && (frame_div == FD_LAST);

  // Frame divider, mode latch and per-mode animation state updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_STATIC;
      frame_div  <= '0;
      reveal_cnt <= '0;
      scroll_ci  <= '0;
      scroll_px  <= '0;
      blink_ph   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (mode_q == MODE_TYPE) && (reveal_cnt == REV_MAX);
      if (mode_chg) begin
        mode_q     <= mode_in;
        frame_div  <= '0;
        reveal_cnt <= '0;
        scroll_ci  <= '0;
        scroll_px  <= '0;
        blink_ph   <= 1'b0;
      end else if (frame_start) begin
        frame_div <= step ? '0 : frame_div + 8'd1;
        if (step) begin
          case (mode_q)
            MODE_TYPE:
              if (reveal_cnt != REV_MAX) reveal_cnt <= reveal_cnt + 5'd1;
            MODE_SCROLL:
              if (scroll_px == PX_LAST) begin
                scroll_px <= '0;
                scroll_ci <= (scroll_ci == CI_LAST) ? '0 : scroll_ci + CI_W'(1);
              end else begin
                scroll_px <= scroll_px + PX_W'(1);
              end
            MODE_BLINK:
              blink_ph <= ~blink_ph;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/text_overlay_anim.sv
// 5x7 text overlay: horizontal char tracker, glyph lookup and registered rgb.
module text_overlay_anim import font5x7_pkg::*; #(
  parameter int                   NUM_CHARS       = 12,
  parameter logic [8*NUM_CHARS-1:0] TEXT          = "WATERLOO ENG",
  parameter int                   SCALE           = 2,
  parameter int                   GAP             = 2,
  parameter int                   TEXT_X0         = 249,
  parameter int                   TEXT_Y0         = 325,
  parameter int                   WIN_W           = NUM_CHARS * (5 * SCALE + GAP) - GAP,
  parameter int                   FRAMES_PER_STEP = 4,
  parameter logic [5:0]           TEXT_COLOR      = 6'b110110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic       frame_start,
  input  logic [1:0] mode,
  output logic [5:0] rgb,
  output logic       done
);

  localparam int PITCH = 5 * SCALE + GAP;
  localparam int SH    = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

  localparam logic [10:0]     X0_V    = 11'(TEXT_X0);
  localparam logic [10:0]     X_END   = 11'(TEXT_X0 + WIN_W);
  localparam logic [10:0]     Y0_V    = 11'(TEXT_Y0);
  localparam logic [10:0]     Y_END   = 11'(TEXT_Y0 + 7 * SCALE);
  localparam logic [PX_W-1:0] GLYPH_W = PX_W'(5 * SCALE);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(PITCH - 1);
  localparam logic [CI_W-1:0] CI_LAST = CI_W'(NUM_CHARS - 1);

  mode_e           mode_q;
  logic [4:0]      reveal_cnt;
  logic [CI_W-1:0] scroll_ci;
  logic [PX_W-1:0] scroll_px;
  logic            blink_ph;

  text_anim_ctrl #(
    .NUM_CHARS      (NUM_CHARS),
    .PITCH          (PITCH),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .mode       (mode),
    .mode_q     (mode_q),
    .reveal_cnt (reveal_cnt),
    .scroll_ci  (scroll_ci),
    .scroll_px  (scroll_px),
    .blink_ph   (blink_ph),
    .done       (done)
  );

  // Character codes unpacked once; unused slots padded with blanks.
  logic [7:0] chars [16];
  for (genvar i = 0; i < 16; i++) begin : g_ch
    if (i < NUM_CHARS) begin : g_txt
      assign chars[i] = TEXT[8*(NUM_CHARS-1-i) +: 8];
    end else begin : g_pad
      assign chars[i] = 8'h20;
    end
  end

  logic [CI_W-1:0] trk_ci, ci, nxt_ci;
  logic [PX_W-1:0] trk_px, px, nxt_px;
  logic [10:0]     xe, ye;
  logic [9:0]      dy;
  logic [2:0]      row, gcol;
  logic [4:0]      bits, sh_bits;
  logic            in_x, in_y, col_ok, anim_ok, on;

  // Tracker: reload from the start pair at the window edge, else use the running position.
  always_comb begin
    xe = {1'b0, x};
    ye = {1'b0, y};
    ci = trk_ci;
    px = trk_px;
    if (xe == X0_V) begin
      ci = (mode_q == MODE_SCROLL) ? scroll_ci : '0;
      px = (mode_q == MODE_SCROLL) ? scroll_px : '0;
    end
    nxt_ci = ci;
    nxt_px = px + PX_W'(1);
    if (px == PX_LAST) begin
      nxt_px = '0;
      nxt_ci = (ci == CI_LAST) ? '0 : ci + CI_W'(1);
    end
  end

  // Glyph lookup and pixel qualification.
  always_comb begin
    dy      = y - 10'(TEXT_Y0);
    row     = 3'(dy >> SH);
    gcol    = 3'(px >> SH);
    col_ok  = px < GLYPH_W;
    bits    = glyph_row(chars[ci], row);
    sh_bits = bits << gcol;
    in_x    = (xe >= X0_V) && (xe < X_END);
    in_y    = (ye >= Y0_V) && (ye < Y_END);
    anim_ok = 1'b1;
    if (mode_q == MODE_TYPE)  anim_ok = 5'(ci) < reveal_cnt;
    if (mode_q == MODE_BLINK) anim_ok = !blink_ph;
    on = active && in_x && in_y && col_ok && sh_bits[4] && anim_ok;
  end

  // Tracker state advances every clk; reloaded each line at the window edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_ci <= '0;
      trk_px <= '0;
    end else begin
      trk_ci <= nxt_ci;
      trk_px <= nxt_px;
    end
  end

  // Registered output pixel, one clk behind x/y/active.
  always_ff @(posedge clk) begin
    if (rst) rgb <= COLOR_TRANSPARENT;
    else     rgb <= on ? TEXT_COLOR : COLOR_TRANSPARENT;
  end

endmodule
